// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter: data width, access-size
// encodings and the grant encoding.
package ram_arbiter_pkg;

    localparam int XLEN   = 64;
    localparam int XBYTES = XLEN / 8;

    typedef enum logic [1:0] {
        MASK_BYTE   = 2'd0,
        MASK_HALF   = 2'd1,
        MASK_WORD   = 2'd2,
        MASK_DOUBLE = 2'd3
    } mask_e;

    typedef enum logic {
        ARB_IF = 1'b0,
        ARB_LS = 1'b1
    } arb_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the IF/LS request-response handshakes and the RAM access port.
// slave = arbiter view, master = core pipeline plus RAM view.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic            if_req_valid;
    logic            if_req_ready;
    logic [XLEN-1:0] if_req_addr;
    logic            if_resp_valid;
    logic            if_resp_ready;
    logic [XLEN-1:0] if_resp_rdata;
    logic            if_resp_err;

    logic            ls_req_valid;
    logic            ls_req_ready;
    logic [XLEN-1:0] ls_req_addr;
    logic            ls_req_wen;
    logic [XLEN-1:0] ls_req_wdata;
    logic [1:0]      ls_req_wmask;
    logic            ls_resp_valid;
    logic            ls_resp_ready;
    logic [XLEN-1:0] ls_resp_rdata;
    logic            ls_resp_err;

    logic [XLEN-1:0] ram_addr_o;
    logic            ram_wen_o;
    logic [XLEN-1:0] ram_wdata_o;
    logic [1:0]      ram_wmask_o;
    logic [XLEN-1:0] ram_rdata_i;

    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_resp_ready,
        input  ram_rdata_i,
        output if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
        output ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
        output ram_addr_o, ram_wen_o, ram_wdata_o, ram_wmask_o
    );

    modport master (
        output if_req_valid, if_req_addr, if_resp_ready,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask, ls_resp_ready,
        output ram_rdata_i,
        input  if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
        input  ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
        input  ram_addr_o, ram_wen_o, ram_wdata_o, ram_wmask_o
    );

endinterface

// File: rtl/ram_fault_check.sv
// Combinational alignment and range check for one RAM access. Every access
// reads an 8-byte window, so the last legal start index is SIZE-8.
module ram_fault_check
    import ram_arbiter_pkg::*;
#(
    parameter int SIZE      = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic [XLEN-1:0] i_addr,
    input  logic [1:0]      i_wmask,
    input  logic            i_is_ifu,
    output logic            o_fault
);

    logic w_misaligned;
    logic w_out_of_range;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_misaligned = 1'b0;
        if (i_is_ifu) begin
            w_misaligned = |i_addr[1:0];
        end else begin
            case (i_wmask)
                MASK_HALF:   w_misaligned = i_addr[0];
                MASK_WORD:   w_misaligned = |i_addr[1:0];
                MASK_DOUBLE: w_misaligned = |i_addr[2:0];
                default:     w_misaligned = 1'b0;
            endcase
        end
    end

    assign w_out_of_range = (|i_addr[XLEN-1:ADDR_BITS]) ||
                            (i_addr[ADDR_BITS-1:0] > ADDR_BITS'(SIZE - XBYTES));

    assign o_fault = w_misaligned || w_out_of_range;

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data-RAM arbiter: LS-priority with an IF starvation guard,
// per-access fault checking and one registered response slot per requester.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int SIZE         = 1024,
    parameter int ADDR_BITS    = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic            w_if_fault;
    logic            w_ls_fault;
    logic            w_if_elig;
    logic            w_ls_elig;
    logic            w_grant_any;
    arb_e            w_grant;
    logic            w_win_if;
    logic            w_win_ls;

    logic [3:0]      r_starve_cnt;
    logic            r_if_resp_valid;
    logic [XLEN-1:0] r_if_resp_rdata;
    logic            r_if_resp_err;
    logic            r_ls_resp_valid;
    logic [XLEN-1:0] r_ls_resp_rdata;
    logic            r_ls_resp_err;

    ram_fault_check #(.SIZE(SIZE), .ADDR_BITS(ADDR_BITS)) u_if_fault (
        .i_addr   (bus.if_req_addr),
        .i_wmask  (MASK_DOUBLE),
        .i_is_ifu (1'b1),
        .o_fault  (w_if_fault)
    );

    ram_fault_check #(.SIZE(SIZE), .ADDR_BITS(ADDR_BITS)) u_ls_fault (
        .i_addr   (bus.ls_req_addr),
        .i_wmask  (bus.ls_req_wmask),
        .i_is_ifu (1'b0),
        .o_fault  (w_ls_fault)
    );

    // A slot that drains this cycle can be refilled in the same cycle.
    assign w_if_elig = bus.if_req_valid && (!r_if_resp_valid || bus.if_resp_ready);
    assign w_ls_elig = bus.ls_req_valid && (!r_ls_resp_valid || bus.ls_resp_ready);

    // NOTE: grants are qualified by rst_n so nothing reaches the RAM, least of all a write, while reset is held.
    assign w_grant_any = rst_n && (w_if_elig || w_ls_elig);

    always_comb begin
        w_grant = ARB_LS;
        if (w_if_elig && w_ls_elig)
            w_grant = (r_starve_cnt == LIMIT) ? ARB_IF : ARB_LS;
        else if (w_if_elig)
            w_grant = ARB_IF;
    end

    assign w_win_if = w_grant_any && (w_grant == ARB_IF);
    assign w_win_ls = w_grant_any && (w_grant == ARB_LS);

    assign bus.if_req_ready = w_win_if;
    assign bus.ls_req_ready = w_win_ls;

    always_comb begin
        bus.ram_addr_o  = '0;
        bus.ram_wen_o   = 1'b0;
        bus.ram_wdata_o = '0;
        bus.ram_wmask_o = MASK_DOUBLE;
        if (w_win_ls) begin
            bus.ram_addr_o  = bus.ls_req_addr;
            bus.ram_wen_o   = bus.ls_req_wen && !w_ls_fault;
            bus.ram_wdata_o = bus.ls_req_wdata;
            bus.ram_wmask_o = bus.ls_req_wmask;
        end else if (w_win_if) begin
            bus.ram_addr_o  = bus.if_req_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_win_if) begin
            r_starve_cnt <= '0;
        end else if (w_if_elig && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_resp_valid <= 1'b0;
            r_if_resp_rdata <= '0;
            r_if_resp_err   <= 1'b0;
        end else if (w_win_if) begin
            r_if_resp_valid <= 1'b1;
            r_if_resp_rdata <= w_if_fault ? '0 : bus.ram_rdata_i;
            r_if_resp_err   <= w_if_fault;
        end else if (bus.if_resp_ready) begin
            r_if_resp_valid <= 1'b0;
        end
    end

    // Stores and faulting loads return zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ls_resp_valid <= 1'b0;
            r_ls_resp_rdata <= '0;
            r_ls_resp_err   <= 1'b0;
        end else if (w_win_ls) begin
            r_ls_resp_valid <= 1'b1;
            r_ls_resp_rdata <= (w_ls_fault || bus.ls_req_wen) ? '0 : bus.ram_rdata_i;
            r_ls_resp_err   <= w_ls_fault;
        end else if (bus.ls_resp_ready) begin
            r_ls_resp_valid <= 1'b0;
        end
    end

    assign bus.if_resp_valid = r_if_resp_valid;
    assign bus.if_resp_rdata = r_if_resp_rdata;
    assign bus.if_resp_err   = r_if_resp_err;
    assign bus.ls_resp_valid = r_ls_resp_valid;
    assign bus.ls_resp_rdata = r_ls_resp_rdata;
    assign bus.ls_resp_err   = r_ls_resp_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single-requester accesses, then
// hand-written starvation, backpressure and mid-stream reset sequences.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    typedef struct {
        logic        if_v;
        logic [63:0] if_a;
        logic        ls_v;
        logic [63:0] ls_a;
        logic        ls_w;
        logic [63:0] ls_d;
        logic [1:0]  ls_m;
        logic        exp_if_rdy;
        logic        exp_ls_rdy;
        logic        exp_wen;
        logic [63:0] exp_addr;
        logic        exp_if_rv;
        logic        exp_ls_rv;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem [1024];
    int         n_checks;
    int         n_errors;
    vec_t       vecs [$];

    ram_arbiter_if bus ();

    ram_arbiter #(.SIZE(1024), .ADDR_BITS(10), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational 8-byte read window, sized write at the edge.
    always_comb begin
        logic [63:0] rd;
        rd = '0;
        for (int k = 0; k < 8; k++)
            rd[8*k +: 8] = mem[10'(bus.ram_addr_o[9:0] + 10'(k))];
        bus.ram_rdata_i = rd;
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mem[16'h10 + i]  = 8'(i + 1);
            mem[16'h3F8 + i] = 8'(8'h11 + i);
        end
        forever begin
            @(posedge clk);
            if (bus.ram_wen_o) begin
                for (int k = 0; k < (1 << bus.ram_wmask_o); k++)
                    mem[10'(bus.ram_addr_o[9:0] + 10'(k))] <= bus.ram_wdata_o[8*k +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.if_req_valid  = 1'b0;
        bus.if_req_addr   = '0;
        bus.if_resp_ready = 1'b1;
        bus.ls_req_valid  = 1'b0;
        bus.ls_req_addr   = '0;
        bus.ls_req_wen    = 1'b0;
        bus.ls_req_wdata  = '0;
        bus.ls_req_wmask  = MASK_DOUBLE;
        bus.ls_resp_ready = 1'b1;
    endtask

    function automatic vec_t v_if(input logic [63:0] a, input logic [63:0] rd, input logic err);
        vec_t v;
        v = '{if_v: 1'b1, if_a: a, ls_v: 1'b0, ls_a: '0, ls_w: 1'b0, ls_d: '0, ls_m: MASK_DOUBLE,
              exp_if_rdy: 1'b1, exp_ls_rdy: 1'b0, exp_wen: 1'b0, exp_addr: a,
              exp_if_rv: 1'b1, exp_ls_rv: 1'b0, exp_rd: rd, exp_err: err};
        return v;
    endfunction

    function automatic vec_t v_ls(input logic [63:0] a, input logic w, input logic [63:0] d,
                                  input logic [1:0] m, input logic wen, input logic [63:0] rd,
                                  input logic err);
        vec_t v;
        v = '{if_v: 1'b0, if_a: '0, ls_v: 1'b1, ls_a: a, ls_w: w, ls_d: d, ls_m: m,
              exp_if_rdy: 1'b0, exp_ls_rdy: 1'b1, exp_wen: wen, exp_addr: a,
              exp_if_rv: 1'b0, exp_ls_rv: 1'b1, exp_rd: rd, exp_err: err};
        return v;
    endfunction

    function automatic logic [63:0] mem_dword(input int base);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = mem[base + k];
        return r;
    endfunction

    initial begin
        logic [6:0] exp_if_win;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive_idle();

        vecs.push_back(v_if(64'h10,  64'h0807060504030201, 1'b0));
        vecs.push_back(v_ls(64'h20,  1'b1, 64'hDEADBEEFCAFEF00D, MASK_DOUBLE, 1'b1, 64'h0, 1'b0));
        vecs.push_back(v_ls(64'h20,  1'b0, 64'h0, MASK_DOUBLE, 1'b0, 64'hDEADBEEFCAFEF00D, 1'b0));
        vecs.push_back(v_ls(64'h22,  1'b1, 64'h11223344, MASK_WORD, 1'b0, 64'h0, 1'b1));
        vecs.push_back(v_ls(64'h20,  1'b0, 64'h0, MASK_DOUBLE, 1'b0, 64'hDEADBEEFCAFEF00D, 1'b0));
        vecs.push_back(v_if(64'h3FC, 64'h0, 1'b1));
        vecs.push_back(v_ls(64'h400, 1'b0, 64'h0, MASK_DOUBLE, 1'b0, 64'h0, 1'b1));
        vecs.push_back(v_if(64'h3F8, 64'h1817161514131211, 1'b0));
        vecs.push_back(v_ls(64'h25,  1'b1, 64'hFFFFFFFFFFFFFFAB, MASK_BYTE, 1'b1, 64'h0, 1'b0));
        vecs.push_back(v_ls(64'h21,  1'b1, 64'h1234, MASK_HALF, 1'b0, 64'h0, 1'b1));
        vecs.push_back(v_ls(64'h26,  1'b1, 64'hFFFFFFFFFFFF1234, MASK_HALF, 1'b1, 64'h0, 1'b0));
        vecs.push_back(v_ls(64'h20,  1'b0, 64'h0, MASK_DOUBLE, 1'b0, 64'h1234ABEFCAFEF00D, 1'b0));
        vecs.push_back(v_if(64'h12,  64'h0, 1'b1));
        vecs.push_back(v_ls(64'h24,  1'b0, 64'h0, MASK_DOUBLE, 1'b0, 64'h0, 1'b1));
        vecs.push_back(v_ls(64'h3F9, 1'b0, 64'h0, MASK_BYTE, 1'b0, 64'h0, 1'b1));
        vecs.push_back(v_ls(64'h3F8, 1'b0, 64'h0, MASK_DOUBLE, 1'b0, 64'h1817161514131211, 1'b0));
        vecs.push_back(v_if(64'h0000000100000010, 64'h0, 1'b1));
        vecs.push_back(v_ls(64'h28,  1'b1, 64'hA5A5A5A589ABCDEF, MASK_WORD, 1'b1, 64'h0, 1'b0));
        vecs.push_back(v_ls(64'h28,  1'b0, 64'h0, MASK_DOUBLE, 1'b0, 64'h0000000089ABCDEF, 1'b0));

        // Reset state, with an LS store request already pending.
        bus.ls_req_valid = 1'b1;
        bus.ls_req_wen   = 1'b1;
        bus.ls_req_addr  = 64'h40;
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_resp_valid", 64'(bus.if_resp_valid), 64'h0);
        check("rst_ls_resp_valid", 64'(bus.ls_resp_valid), 64'h0);
        check("rst_if_rdata", bus.if_resp_rdata, 64'h0);
        check("rst_ls_err", 64'(bus.ls_resp_err), 64'h0);
        check("rst_ram_wen", 64'(bus.ram_wen_o), 64'h0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.if_req_valid = vecs[i].if_v;
            bus.if_req_addr  = vecs[i].if_a;
            bus.ls_req_valid = vecs[i].ls_v;
            bus.ls_req_addr  = vecs[i].ls_a;
            bus.ls_req_wen   = vecs[i].ls_w;
            bus.ls_req_wdata = vecs[i].ls_d;
            bus.ls_req_wmask = vecs[i].ls_m;
            #1;
            check($sformatf("v%0d_if_req_ready", i), 64'(bus.if_req_ready), 64'(vecs[i].exp_if_rdy));
            check($sformatf("v%0d_ls_req_ready", i), 64'(bus.ls_req_ready), 64'(vecs[i].exp_ls_rdy));
            check($sformatf("v%0d_ram_wen", i), 64'(bus.ram_wen_o), 64'(vecs[i].exp_wen));
            check($sformatf("v%0d_ram_addr", i), bus.ram_addr_o, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_if_resp_valid", i), 64'(bus.if_resp_valid), 64'(vecs[i].exp_if_rv));
            check($sformatf("v%0d_ls_resp_valid", i), 64'(bus.ls_resp_valid), 64'(vecs[i].exp_ls_rv));
            if (vecs[i].exp_if_rv) begin
                check($sformatf("v%0d_if_rdata", i), bus.if_resp_rdata, vecs[i].exp_rd);
                check($sformatf("v%0d_if_err", i), 64'(bus.if_resp_err), 64'(vecs[i].exp_err));
            end else begin
                check($sformatf("v%0d_ls_rdata", i), bus.ls_resp_rdata, vecs[i].exp_rd);
                check($sformatf("v%0d_ls_err", i), 64'(bus.ls_resp_err), 64'(vecs[i].exp_err));
            end
            @(negedge clk);
            drive_idle();
        end

        // Starvation guard: LS wins four conflicts, IF wins the fifth, then LS again.
        exp_if_win = 7'b0010000;
        @(negedge clk);
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 64'h10;
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 64'h20;
        for (int c = 0; c < 7; c++) begin
            #1;
            check($sformatf("starve_c%0d_if_ready", c), 64'(bus.if_req_ready), 64'(exp_if_win[c]));
            check($sformatf("starve_c%0d_ls_ready", c), 64'(bus.ls_req_ready), 64'(!exp_if_win[c]));
            @(negedge clk);
        end
        drive_idle();
        @(negedge clk);

        // Backpressure on the IF response slot.
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'h10;
        bus.if_resp_ready = 1'b0;
        #1;
        check("bp_first_if_ready", 64'(bus.if_req_ready), 64'h1);
        @(posedge clk);
        #1;
        check("bp_first_if_resp_valid", 64'(bus.if_resp_valid), 64'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.ls_req_valid = 1'b1;
            bus.ls_req_addr  = 64'h20;
            #1;
            check($sformatf("bp_c%0d_if_ready", c), 64'(bus.if_req_ready), 64'h0);
            check($sformatf("bp_c%0d_ls_ready", c), 64'(bus.ls_req_ready), 64'h1);
            @(posedge clk);
            #1;
            check($sformatf("bp_c%0d_if_resp_valid", c), 64'(bus.if_resp_valid), 64'h1);
            check($sformatf("bp_c%0d_if_rdata", c), bus.if_resp_rdata, 64'h0807060504030201);
            check($sformatf("bp_c%0d_ls_rdata", c), bus.ls_resp_rdata, 64'h1234ABEFCAFEF00D);
        end
        @(negedge clk);
        bus.ls_req_valid  = 1'b0;
        bus.if_resp_ready = 1'b1;
        #1;
        check("bp_refill_if_ready", 64'(bus.if_req_ready), 64'h1);
        @(posedge clk);
        #1;
        check("bp_refill_if_resp_valid", 64'(bus.if_resp_valid), 64'h1);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        check("bp_drained_if_resp_valid", 64'(bus.if_resp_valid), 64'h0);

        // Asynchronous reset with responses pending and a store requesting.
        @(negedge clk);
        bus.ls_req_valid  = 1'b1;
        bus.ls_req_wen    = 1'b1;
        bus.ls_req_addr   = 64'h30;
        bus.ls_req_wdata  = 64'h5555555555555555;
        bus.ls_resp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("arst_pending_ls_valid", 64'(bus.ls_resp_valid), 64'h1);
        @(negedge clk);
        bus.ls_req_wdata  = 64'h6666666666666666;
        bus.ls_resp_ready = 1'b1;
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 64'h10;
        bus.if_resp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ls_resp_valid", 64'(bus.ls_resp_valid), 64'h0);
        check("arst_if_resp_valid", 64'(bus.if_resp_valid), 64'h0);
        check("arst_ram_wen", 64'(bus.ram_wen_o), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("arst_mem_unchanged", mem_dword(32'h30), 64'h5555555555555555);
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_after_ls_valid", 64'(bus.ls_resp_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
